fila_pedidos_cafe: RTL and testbench

Order-queue front end for the coffee machine FSM (`maquina_maluca`). It debounces a raw front-panel button and counts pending coffee orders up to a fixed limit. It issues `start` to the machine only when the machine reports IDLE, then tracks the machine's `state` until the brew completes. It sits directly upstream of `maquina_maluca`: drives its `start` and consumes its `state`.

---
 rtl/cafe_pkg.sv | 24 ++
 rtl/debounce_botao.sv | 43 ++++
 rtl/fila_pedidos_cafe.sv | 119 +++++++++++
 tb/tb_fila_pedidos_cafe.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cafe_pkg.sv
// Shared definitions for the coffee machine (maquina_maluca) and its order-queue front end.
package cafe_pkg;

  // State encodings reported by maquina_maluca on its state output.
  typedef enum logic [3:0] {
    MAQ_IDLE                = 4'd1,
    MAQ_LIGAR_MAQUINA       = 4'd2,
    MAQ_VERIFICAR_AGUA      = 4'd3,
    MAQ_ENCHER_RESERVATORIO = 4'd4,
    MAQ_VERIFICAR_PO        = 4'd5,
    MAQ_ADICIONAR_PO        = 4'd6,
    MAQ_VERIFICAR_COPO      = 4'd7,
    MAQ_COLOCAR_COPO        = 4'd8,
    MAQ_REALIZAR_EXTRACAO   = 4'd9
  } estado_maquina_t;

  // Order-queue FSM.
  typedef enum logic [1:0] {
    ESPERA     = 2'd0,
    DISPARO    = 2'd1,
    PREPARANDO = 2'd2
  } estado_fila_t;

endpackage

// File: rtl/debounce_botao.sv
// Two-flop synchronizer followed by a stability counter; emits a one-cycle pulse
// on each accepted rising edge of the button level.
module debounce_botao #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic nivel,
  output logic subida
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      nivel  <= 1'b0;
      subida <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1  <= in;
      sync2  <= sync1;
      subida <= 1'b0;
      if (sync2 == nivel) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        // Level accepted; only the low-to-high change counts as a press.
        nivel  <= sync2;
        subida <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/fila_pedidos_cafe.sv
// Coffee order queue: counts debounced button presses and dispatches them one at a
// time to maquina_maluca, following its state until each brew completes.
module fila_pedidos_cafe
  import cafe_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_PEDIDOS     = 7,
  parameter int PEND_W          = 3,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              botao,
  input  logic [3:0]        state_in,
  output logic              start,
  output logic [PEND_W-1:0] pendentes,
  output logic              cheio,
  output logic              descartado,
  output logic              concluido,
  output logic              erro,
  output estado_fila_t      dbg_estado,
  output logic              dbg_nivel
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  estado_fila_t  estado;
  logic [TW-1:0] tmo;
  logic          visto_extracao;
  logic          pedido;
  logic          conclui;

  debounce_botao #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (botao),
    .nivel (dbg_nivel),
    .subida(pedido)
  );

  assign conclui    = (estado == PREPARANDO) && (state_in == MAQ_IDLE) && visto_extracao;
  assign cheio      = (pendentes == PEND_W'(MAX_PEDIDOS));
  assign dbg_estado = estado;

  // A press and a completion in the same cycle cancel out, so nothing is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pendentes  <= '0;
      descartado <= 1'b0;
    end else begin
      descartado <= 1'b0;
      if (pedido && !conclui) begin
        if (pendentes < PEND_W'(MAX_PEDIDOS)) begin
          pendentes <= pendentes + PEND_W'(1);
        end else begin
          descartado <= 1'b1;
        end
      end else if (conclui && !pedido) begin
        pendentes <= pendentes - PEND_W'(1);
      end
    end
  end

  // start is a level request held while in DISPARO; the machine acknowledges it by
  // moving to LIGAR_MAQUINA, and a brew is done when it returns to IDLE after extraction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado         <= ESPERA;
      start          <= 1'b0;
      concluido      <= 1'b0;
      erro           <= 1'b0;
      tmo            <= '0;
      visto_extracao <= 1'b0;
    end else begin
      concluido <= 1'b0;
      case (estado)
        ESPERA: begin
          if ((pendentes != '0) && (state_in == MAQ_IDLE)) begin
            estado <= DISPARO;
            start  <= 1'b1;
            tmo    <= '0;
          end
        end
        DISPARO: begin
          if (state_in == MAQ_LIGAR_MAQUINA) begin
            estado         <= PREPARANDO;
            start          <= 1'b0;
            visto_extracao <= 1'b0;
          end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
            estado <= ESPERA;
            start  <= 1'b0;
            erro   <= 1'b1;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        PREPARANDO: begin
          if (state_in == MAQ_IDLE) begin
            estado <= ESPERA;
            if (visto_extracao) begin
              concluido <= 1'b1;
            end else begin
              erro <= 1'b1;
            end
          end else if (state_in == MAQ_REALIZAR_EXTRACAO) begin
            visto_extracao <= 1'b1;
          end
        end
        default: begin
          estado <= ESPERA;
          start  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fila_pedidos_cafe.sv
// Bench for fila_pedidos_cafe with a small behavioural model of maquina_maluca.
module tb_fila_pedidos_cafe;
  import cafe_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         botao;
  logic [3:0]   state_in;
  logic         start;
  logic [2:0]   pendentes;
  logic         cheio;
  logic         descartado;
  logic         concluido;
  logic         erro;
  estado_fila_t dbg_estado;
  logic         dbg_nivel;

  fila_pedidos_cafe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .botao     (botao),
    .state_in  (state_in),
    .start     (start),
    .pendentes (pendentes),
    .cheio     (cheio),
    .descartado(descartado),
    .concluido (concluido),
    .erro      (erro),
    .dbg_estado(dbg_estado),
    .dbg_nivel (dbg_nivel)
  );

  // ---------------- machine model ----------------
  logic       forcar;
  logic [3:0] forca_val;
  logic [3:0] maq_st;
  logic       maq_busy;
  int         maq_idx;

  function automatic logic [3:0] seq_at(input int i);
    case (i)
      0: seq_at = 4'd2;
      1: seq_at = 4'd3;
      2: seq_at = 4'd4;
      3: seq_at = 4'd3;
      4: seq_at = 4'd5;
      5: seq_at = 4'd6;
      6: seq_at = 4'd7;
      7: seq_at = 4'd8;
      8: seq_at = 4'd9;
      default: seq_at = 4'd1;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      maq_st   <= 4'd1;
      maq_busy <= 1'b0;
      maq_idx  <= 0;
    end else if (!maq_busy) begin
      if (start && maq_st == 4'd1) begin
        maq_st   <= seq_at(0);
        maq_idx  <= 1;
        maq_busy <= 1'b1;
      end
    end else begin
      maq_st  <= seq_at(maq_idx);
      maq_idx <= maq_idx + 1;
      if (maq_idx == 9) maq_busy <= 1'b0;
    end
  end

  assign state_in = forcar ? forca_val : maq_st;

  // ---------------- scoreboard ----------------
  logic [2:0] exp_q[$];
  logic [2:0] obs_q[$];
  logic [2:0] last_pend = 3'd0;
  int         exp_pend = 0;
  int         n_start = 0;
  int         n_desc = 0;
  int         n_conc = 0;
  int         checks = 0;
  int         errors = 0;

  always @(negedge clk) begin
    if (pendentes !== last_pend) begin
      obs_q.push_back(pendentes);
      last_pend = pendentes;
    end
    if (start === 1'b1) n_start++;
    if (descartado === 1'b1) n_desc++;
    if (concluido === 1'b1) n_conc++;
  end

  // ---------------- driver tasks ----------------
  task automatic press();
    botao = 1'b1;
    repeat (10) @(negedge clk);
    botao = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_reset();
    if (exp_pend != 0) exp_q.push_back(3'd0);
    exp_pend = 0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL rst_start got %b exp 0", start); end
    checks++; if (pendentes !== 3'd0) begin errors++; $display("FAIL rst_pendentes got %0d exp 0", pendentes); end
    checks++; if (cheio !== 1'b0) begin errors++; $display("FAIL rst_cheio got %b exp 0", cheio); end
    checks++; if (descartado !== 1'b0) begin errors++; $display("FAIL rst_descartado got %b exp 0", descartado); end
    checks++; if (concluido !== 1'b0) begin errors++; $display("FAIL rst_concluido got %b exp 0", concluido); end
    checks++; if (erro !== 1'b0) begin errors++; $display("FAIL rst_erro got %b exp 0", erro); end
    checks++; if (dbg_estado !== ESPERA) begin errors++; $display("FAIL rst_estado got %0d exp %0d", dbg_estado, ESPERA); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_press();
    int b_start, b_conc;
    logic [2:0] e, o;
    b_start = n_start;
    b_conc  = n_conc;
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd0);
    botao = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 9) botao = 1'b0;
      if (k == 5) begin checks++; if (pendentes !== 3'd0) begin errors++; $display("FAIL single_pend_e5 got %0d exp 0", pendentes); end end
      if (k == 6) begin checks++; if (pendentes !== 3'd1) begin errors++; $display("FAIL single_pend_e6 got %0d exp 1", pendentes); end end
      if (k == 7) begin checks++; if (start !== 1'b1) begin errors++; $display("FAIL single_start_e7 got %b exp 1", start); end end
      if (k == 9) begin checks++; if (start !== 1'b0) begin errors++; $display("FAIL single_start_e9 got %b exp 0", start); end end
      if (k == 17) begin checks++; if (concluido !== 1'b0) begin errors++; $display("FAIL single_conc_e17 got %b exp 0", concluido); end end
      if (k == 18) begin checks++; if (concluido !== 1'b1) begin errors++; $display("FAIL single_conc_e18 got %b exp 1", concluido); end end
    end
    checks++; if (n_start - b_start != 2) begin errors++; $display("FAIL single_start_cycles got %0d exp 2", n_start - b_start); end
    checks++; if (n_conc - b_conc != 1) begin errors++; $display("FAIL single_conc_pulses got %0d exp 1", n_conc - b_conc); end
    checks++; if (erro !== 1'b0) begin errors++; $display("FAIL single_erro got %b exp 0", erro); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL single_sb got none exp %0d", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL single_sb got %0d exp %0d", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL single_sb_extra got %0d extra exp 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_bouncy();
    int b_conc, b_desc;
    logic [2:0] e, o;
    b_conc = n_conc;
    b_desc = n_desc;
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd0);
    botao = 1'b1; @(negedge clk);
    botao = 1'b0; @(negedge clk);
    botao = 1'b1;
    repeat (10) @(negedge clk);
    botao = 1'b0;
    repeat (40) @(negedge clk);
    checks++; if (n_conc - b_conc != 1) begin errors++; $display("FAIL bouncy_conc got %0d exp 1", n_conc - b_conc); end
    checks++; if (n_desc - b_desc != 0) begin errors++; $display("FAIL bouncy_desc got %0d exp 0", n_desc - b_desc); end
    checks++; if (pendentes !== 3'd0) begin errors++; $display("FAIL bouncy_pend got %0d exp 0", pendentes); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL bouncy_sb got none exp %0d", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL bouncy_sb got %0d exp %0d", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL bouncy_sb_extra got %0d extra exp 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_saturate();
    int b_desc, b_start;
    logic [2:0] e, o;
    forcar    = 1'b1;
    forca_val = 4'd4;
    b_desc  = n_desc;
    b_start = n_start;
    for (int k = 1; k <= 9; k++) begin
      if (exp_pend < 7) begin
        exp_pend++;
        exp_q.push_back(3'(exp_pend));
      end
      press();
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    checks++; if (pendentes !== 3'd7) begin errors++; $display("FAIL sat_pend got %0d exp 7", pendentes); end
    checks++; if (cheio !== 1'b1) begin errors++; $display("FAIL sat_cheio got %b exp 1", cheio); end
    checks++; if (n_desc - b_desc != 2) begin errors++; $display("FAIL sat_desc got %0d exp 2", n_desc - b_desc); end
    checks++; if (n_start - b_start != 0) begin errors++; $display("FAIL sat_start got %0d exp 0", n_start - b_start); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL sat_sb got none exp %0d", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL sat_sb got %0d exp %0d", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL sat_sb_extra got %0d extra exp 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_simultaneous();
    int b_desc, b_conc;
    logic [2:0] e, o;
    b_desc = n_desc;
    b_conc = n_conc;
    forca_val = 4'd1; repeat (2) @(negedge clk);
    forca_val = 4'd2; repeat (2) @(negedge clk);
    forca_val = 4'd9; repeat (2) @(negedge clk);
    forca_val = 4'd4; @(negedge clk);
    botao = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 5) forca_val = 4'd1;
      if (k == 6) begin
        checks++; if (pendentes !== 3'd7) begin errors++; $display("FAIL simul_pend got %0d exp 7", pendentes); end
        checks++; if (concluido !== 1'b1) begin errors++; $display("FAIL simul_conc got %b exp 1", concluido); end
        forca_val = 4'd4;
      end
    end
    botao = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (n_desc - b_desc != 0) begin errors++; $display("FAIL simul_desc got %0d exp 0", n_desc - b_desc); end
    checks++; if (n_conc - b_conc != 1) begin errors++; $display("FAIL simul_conc_pulses got %0d exp 1", n_conc - b_conc); end
    do_reset();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL simul_sb got none exp %0d", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL simul_sb got %0d exp %0d", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL simul_sb_extra got %0d extra exp 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_timeout();
    int b_start;
    logic seen;
    logic [2:0] e, o;
    forca_val = 4'd5;
    b_start = n_start;
    for (int k = 0; k < 2; k++) begin
      exp_pend++;
      exp_q.push_back(3'(exp_pend));
      press();
    end
    repeat (5) @(negedge clk);
    checks++; if (n_start - b_start != 0) begin errors++; $display("FAIL tmo_no_start got %0d exp 0", n_start - b_start); end
    checks++; if (erro !== 1'b0) begin errors++; $display("FAIL tmo_erro_before got %b exp 0", erro); end
    b_start = n_start;
    forca_val = 4'd1;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (erro === 1'b1) seen = 1'b1;
    end
    forca_val = 4'd5;
    @(negedge clk);
    checks++; if (!seen) begin errors++; $display("FAIL tmo_wait got erro 0 exp 1 within 60 cycles"); end
    checks++; if (n_start - b_start != 16) begin errors++; $display("FAIL tmo_start_cycles got %0d exp 16", n_start - b_start); end
    checks++; if (pendentes !== 3'd2) begin errors++; $display("FAIL tmo_pend got %0d exp 2", pendentes); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL tmo_sb got none exp %0d", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL tmo_sb got %0d exp %0d", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL tmo_sb_extra got %0d extra exp 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_reset_mid();
    logic [2:0] e, o;
    exp_pend++;
    exp_q.push_back(3'(exp_pend));
    press();
    forca_val = 4'd1; repeat (2) @(negedge clk);
    forca_val = 4'd2; repeat (2) @(negedge clk);
    checks++; if (dbg_estado !== PREPARANDO) begin errors++; $display("FAIL mid_estado got %0d exp %0d", dbg_estado, PREPARANDO); end
    checks++; if (pendentes !== 3'd3) begin errors++; $display("FAIL mid_pend_before got %0d exp 3", pendentes); end
    exp_q.push_back(3'd0);
    exp_pend = 0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL mid_start got %b exp 0", start); end
    checks++; if (pendentes !== 3'd0) begin errors++; $display("FAIL mid_pend got %0d exp 0", pendentes); end
    checks++; if (cheio !== 1'b0) begin errors++; $display("FAIL mid_cheio got %b exp 0", cheio); end
    checks++; if (descartado !== 1'b0) begin errors++; $display("FAIL mid_desc got %b exp 0", descartado); end
    checks++; if (concluido !== 1'b0) begin errors++; $display("FAIL mid_conc got %b exp 0", concluido); end
    checks++; if (erro !== 1'b0) begin errors++; $display("FAIL mid_erro got %b exp 0", erro); end
    checks++; if (dbg_estado !== ESPERA) begin errors++; $display("FAIL mid_estado_rst got %0d exp %0d", dbg_estado, ESPERA); end
    @(negedge clk);
    rst_n  = 1'b1;
    forcar = 1'b0;
    repeat (5) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL mid_sb got none exp %0d", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL mid_sb got %0d exp %0d", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL mid_sb_extra got %0d extra exp 0", obs_q.size()); obs_q.delete(); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n     = 1'b0;
    botao     = 1'b0;
    forcar    = 1'b0;
    forca_val = 4'd1;
    test_reset();
    test_single_press();
    test_bouncy();
    test_saturate();
    test_simultaneous();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
